axis_pixel_unpacker: RTL and testbench

AXI4-Stream video sink that receives the packed 32-bit pixel stream produced by the fractal pixel path and unpacks it into one 24-bit RGB pixel per transfer. It tracks pixel coordinates and checks framing markers: start-of-frame on `tuser`, end-of-line on `tlast`. It sits at the receive end of the stream, feeding on-chip consumers such as a frame checker, a line buffer or a simulation pixel dump. Packing is byte-serial: r0,g0,b0,r1,g1,b1,…, with the first byte in `tdata[7:0]`. Four pixels occupy three words.

---
 rtl/video_stream_pkg.sv | 27 ++
 rtl/unpacker_xy_counter.sv | 42 ++++
 rtl/axis_pixel_unpacker.sv | 143 ++++++++++++++
 tb/tb_axis_pixel_unpacker.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_stream_pkg.sv
// Shared types and defaults for the packed 24-bit RGB video stream.
package video_stream_pkg;

   localparam int X_SIZE_DEF = 640;
   localparam int Y_SIZE_DEF = 480;
   localparam int X_W        = 10;
   localparam int Y_W        = 9;

   typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

   // r is the first byte on the wire, so it occupies the low byte
   typedef struct packed {
      logic [7:0] b;
      logic [7:0] g;
      logic [7:0] r;
   } rgb_t;

   function automatic phase_t next_phase(input phase_t p);
      case (p)
         P0:      return P1;
         P1:      return P2;
         P2:      return P3;
         default: return P0;
      endcase
   endfunction

endpackage

// File: rtl/unpacker_xy_counter.sv
// Pixel coordinate counter with advance and synchronous clear; flags describe
// the coordinate the next loaded pixel will carry.
module unpacker_xy_counter
   import video_stream_pkg::*;
#(
   parameter int X_SIZE = X_SIZE_DEF,
   parameter int Y_SIZE = Y_SIZE_DEF
) (
   input  logic           aclk,
   input  logic           aresetn,
   input  logic           adv,
   input  logic           clr,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           sof,
   output logic           eol,
   output logic           eof
);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         x <= '0;
         y <= '0;
      end else if (clr) begin
         // a clear that coincides with a load means (0,0) was just used
         x <= adv ? X_W'(1) : '0;
         y <= '0;
      end else if (adv) begin
         if (x == X_W'(X_SIZE - 1)) begin
            x <= '0;
            y <= (y == Y_W'(Y_SIZE - 1)) ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

   assign sof = (x == '0) && (y == '0);
   assign eol = (x == X_W'(X_SIZE - 1));
   assign eof = eol && (y == Y_W'(Y_SIZE - 1));

endmodule

// File: rtl/axis_pixel_unpacker.sv
// Unpacks a byte-serial 32-bit RGB stream into one pixel per transfer.
// Framing checks and resynchronisation are built only with UNPACKER_CHECK_EN.
module axis_pixel_unpacker
   import video_stream_pkg::*;
#(
   parameter int X_SIZE = X_SIZE_DEF,
   parameter int Y_SIZE = Y_SIZE_DEF
) (
   input  logic           aclk,
   input  logic           aresetn,
   input  logic [31:0]    in_stream_tdata,
   input  logic [3:0]     in_stream_tkeep,
   input  logic           in_stream_tlast,
   input  logic           in_stream_tuser,
   input  logic           in_stream_tvalid,
   output logic           in_stream_tready,
   output logic [7:0]     pix_r,
   output logic [7:0]     pix_g,
   output logic [7:0]     pix_b,
   output logic [X_W-1:0] pix_x,
   output logic [Y_W-1:0] pix_y,
   output logic           pix_sof,
   output logic           pix_eol,
   output logic           pix_eof,
   output logic           pix_valid,
   input  logic           pix_ready,
   output logic           err_sof,
   output logic           err_eol
);

   phase_t         phase, eff_phase;
   rgb_t           pix, pix_d;
   logic [23:0]    held, held_d;
   logic           ready_en, out_free, hs, load, resync;
   logic [X_W-1:0] cnt_x, eff_x;
   logic [Y_W-1:0] cnt_y, eff_y;
   logic           c_sof, c_eol, c_eof;

   assign out_free         = !pix_valid || pix_ready;
   assign in_stream_tready = ready_en && (phase != P3) && out_free;
   assign hs               = in_stream_tvalid && in_stream_tready;
   assign load             = out_free && ((phase == P3) || hs);

   unpacker_xy_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE)) u_xy (
      .aclk    (aclk),
      .aresetn (aresetn),
      .adv     (load),
      .clr     (resync),
      .x       (cnt_x),
      .y       (cnt_y),
      .sof     (c_sof),
      .eol     (c_eol),
      .eof     (c_eof)
   );

   // a resynchronising word is decoded as w0 of pixel (0,0)
   assign eff_phase = resync ? P0 : phase;
   assign eff_x     = resync ? '0 : cnt_x;
   assign eff_y     = resync ? '0 : cnt_y;

`ifdef UNPACKER_CHECK_EN
   logic at_origin, exp_last, unused_keep;

   assign at_origin   = (phase == P0) && c_sof;
   assign resync      = hs && in_stream_tuser && !at_origin;
   assign exp_last    = (eff_phase == P2) && (eff_x == X_W'(X_SIZE - 2));
   assign unused_keep = ^in_stream_tkeep;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         err_sof <= 1'b0;
         err_eol <= 1'b0;
      end else begin
         if (hs && (in_stream_tuser != at_origin)) err_sof <= 1'b1;
         if (hs && (in_stream_tlast != exp_last))  err_eol <= 1'b1;
      end
   end
`else
   logic unused_framing;

   assign resync         = 1'b0;
   assign err_sof        = 1'b0;
   assign err_eol        = 1'b0;
   assign unused_framing = ^{in_stream_tkeep, in_stream_tlast, in_stream_tuser};
`endif

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      pix_d  = held;
      held_d = held;
      case (eff_phase)
         P0: begin
            pix_d  = in_stream_tdata[23:0];
            held_d = {16'h0, in_stream_tdata[31:24]};
         end
         P1: begin
            pix_d  = {in_stream_tdata[15:0], held[7:0]};
            held_d = {8'h0, in_stream_tdata[31:16]};
         end
         P2: begin
            pix_d  = {in_stream_tdata[7:0], held[15:0]};
            held_d = in_stream_tdata[31:8];
         end
         default: ;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ready_en  <= 1'b0;
         phase     <= P0;
         held      <= '0;
         pix       <= '0;
         pix_valid <= 1'b0;
         pix_x     <= '0;
         pix_y     <= '0;
         pix_sof   <= 1'b0;
         pix_eol   <= 1'b0;
         pix_eof   <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (load) begin
            phase     <= next_phase(eff_phase);
            held      <= held_d;
            pix       <= pix_d;
            pix_valid <= 1'b1;
            pix_x     <= eff_x;
            pix_y     <= eff_y;
            pix_sof   <= resync || c_sof;
            pix_eol   <= !resync && c_eol;
            pix_eof   <= !resync && c_eof;
         end else if (pix_ready) begin
            pix_valid <= 1'b0;
         end
      end
   end

   assign pix_r = pix.r;
   assign pix_g = pix.g;
   assign pix_b = pix.b;

endmodule

// File: tb/tb_axis_pixel_unpacker.sv
// Scoreboard bench for axis_pixel_unpacker: a byte-queue reference model predicts
// pixels and coordinates, a negedge monitor compares every pixel handshake.
module tb_axis_pixel_unpacker;

   localparam int XS  = 8;
   localparam int YS  = 2;
   localparam int WPL = XS * 3 / 4;
   localparam int WPF = WPL * YS;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] in_stream_tdata = '0;
   logic [3:0]  in_stream_tkeep = 4'hF;
   logic        in_stream_tlast = 1'b0;
   logic        in_stream_tuser = 1'b0;
   logic        in_stream_tvalid = 1'b0;
   logic        in_stream_tready;
   logic [7:0]  pix_r, pix_g, pix_b;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic        pix_sof, pix_eol, pix_eof, pix_valid;
   logic        pix_ready = 1'b1;
   logic        err_sof, err_eol;

   axis_pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
      .aclk             (aclk),
      .aresetn          (aresetn),
      .in_stream_tdata  (in_stream_tdata),
      .in_stream_tkeep  (in_stream_tkeep),
      .in_stream_tlast  (in_stream_tlast),
      .in_stream_tuser  (in_stream_tuser),
      .in_stream_tvalid (in_stream_tvalid),
      .in_stream_tready (in_stream_tready),
      .pix_r            (pix_r),
      .pix_g            (pix_g),
      .pix_b            (pix_b),
      .pix_x            (pix_x),
      .pix_y            (pix_y),
      .pix_sof          (pix_sof),
      .pix_eol          (pix_eol),
      .pix_eof          (pix_eof),
      .pix_valid        (pix_valid),
      .pix_ready        (pix_ready),
      .err_sof          (err_sof),
      .err_eol          (err_eol)
   );

   always #5 aclk = ~aclk;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
   logic [63:0] exp_q[$];
   logic [7:0]  byte_q[$];
   int          hs_cyc[$];
   int          pix_idx = 0;
   int          word_idx = 0;

   always @(posedge aclk) cyc <= cyc + 1;

   always @(posedge aclk) begin
      #1;
      case (ready_mode)
         0:       pix_ready = 1'b1;
         2:       pix_ready = 1'b0;
         default: pix_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] pack(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b, input logic [9:0] x,
                                        input logic [8:0] y, input logic sof,
                                        input logic eol, input logic eof);
      return {18'h0, r, g, b, x, y, sof, eol, eof};
   endfunction

   // Reference model: bytes go into a FIFO, every three bytes form a pixel,
   // and the coordinate is simply the pixel index within the frame.
   function automatic void model_word(input logic [31:0] d, input logic user);
      logic [7:0] r, g, b;
      int         x, y;
`ifdef UNPACKER_CHECK_EN
      if (user && (byte_q.size() != 0 || pix_idx != 0)) begin
         byte_q.delete();
         pix_idx  = 0;
         word_idx = 1;
      end
`endif
      for (int i = 0; i < 4; i++) byte_q.push_back(d[8*i +: 8]);
      while (byte_q.size() >= 3) begin
         r = byte_q.pop_front();
         g = byte_q.pop_front();
         b = byte_q.pop_front();
         x = pix_idx % XS;
         y = pix_idx / XS;
         exp_q.push_back(pack(r, g, b, 10'(x), 9'(y), pix_idx == 0, x == XS - 1,
                              pix_idx == XS * YS - 1));
         pix_idx = (pix_idx + 1) % (XS * YS);
      end
   endfunction

   task automatic send_word(input logic [31:0] d, input logic user, input logic last);
      int n = 0;
      in_stream_tdata  = d;
      in_stream_tuser  = user;
      in_stream_tlast  = last;
      in_stream_tvalid = 1'b1;
      do begin
         @(negedge aclk);
         n++;
      end while (!in_stream_tready && n < 200);
      if (!in_stream_tready) begin
         check("tready_wait", {63'h0, in_stream_tready}, 64'h1);
      end else begin
         hs_cyc.push_back(cyc);
         model_word(d, user);
      end
      @(posedge aclk);
      #1;
      in_stream_tvalid = 1'b0;
   endtask

   task automatic send_auto(input logic [31:0] d);
      logic u, l;
      u = (word_idx % WPF) == 0;
      l = (word_idx % WPL) == WPL - 1;
      word_idx++;
      send_word(d, u, l);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge aclk);
         n++;
      end
      idle(2);
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic reset_dut();
      @(posedge aclk);
      #1;
      aresetn          = 1'b0;
      in_stream_tvalid = 1'b0;
      #1;
      check("rst_valid", {63'h0, pix_valid}, 64'h0);
      check("rst_xy", {pix_x, pix_y}, 64'h0);
      check("rst_tready", {63'h0, in_stream_tready}, 64'h0);
      exp_q.delete();
      byte_q.delete();
      pix_idx  = 0;
      word_idx = 0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      idle(1);
   endtask

   // Monitor: pops the scoreboard on every pixel handshake and checks that a
   // stalled pixel stays put with the input side blocked.
   logic [63:0] snap;
   bit          stalled = 1'b0;
   always @(negedge aclk) begin
      if (!aresetn) begin
         stalled = 1'b0;
      end else begin
         if (stalled)
            check("stall_stable", {pix_valid, pack(pix_r, pix_g, pix_b, pix_x, pix_y,
                                   pix_sof, pix_eol, pix_eof)}, snap);
         if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0)
               check("unexpected_pixel", {63'h0, pix_valid}, 64'h0);
            else
               check("pixel", pack(pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol,
                                   pix_eof), exp_q.pop_front());
         end
         if (pix_valid && !pix_ready) begin
            check("stall_tready", {63'h0, in_stream_tready}, 64'h0);
            snap    = {1'b1, pack(pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol,
                                  pix_eof)};
            stalled = 1'b1;
         end else begin
            stalled = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge aclk);
      #1;
      check("rst_valid0", {63'h0, pix_valid}, 64'h0);
      check("rst_rgb0", {pix_r, pix_g, pix_b}, 64'h0);
      check("rst_xy0", {pix_x, pix_y}, 64'h0);
      check("rst_flags0", {pix_sof, pix_eol, pix_eof}, 64'h0);
      check("rst_err0", {err_sof, err_eol}, 64'h0);
      check("rst_tready0", {63'h0, in_stream_tready}, 64'h0);
      @(negedge aclk);
      aresetn = 1'b1;
      idle(1);

      // Single known group, then the rest of the frame and a second frame
      ready_mode = 0;
      send_auto(32'h4433_2211);
      send_auto(32'h8877_6655);
      send_auto(32'hCCBB_AA99);
      for (int i = 0; i < 9 + WPF; i++) send_auto($urandom());
      drain();
      check("err_after_frames", {err_sof, err_eol}, 64'h0);

      // Throughput: back-to-back words with an always-ready sink
      hs_cyc.delete();
      fork
         begin
            for (int i = 0; i < 12; i++) send_auto($urandom());
         end
         begin
            int lows = 0;
            int n = 0;
            while (hs_cyc.size() == 0 && n < 100) begin
               @(negedge aclk);
               n++;
            end
            repeat (15) begin
               @(negedge aclk);
               if (!pix_valid) lows++;
            end
            check("tput_valid_low", lows, 0);
         end
      join
      check("tput_words", hs_cyc.size(), 12);
      if (hs_cyc.size() == 12)
         for (int i = 1; i < 12; i++)
            check("tput_gap", hs_cyc[i] - hs_cyc[i-1], (i % 3 == 0) ? 2 : 1);
      drain();

      // Backpressure: sink stalls for five cycles in the middle of a group
      fork
         begin
            for (int i = 0; i < 3; i++) send_auto($urandom());
         end
         begin
            idle(2);
            ready_mode = 2;
            idle(5);
            ready_mode = 0;
         end
      join
      drain();

      // Random traffic with random sink readiness and idle gaps
      ready_mode = 1;
      for (int i = 0; i < 45; i++) begin
         send_auto($urandom());
         idle($urandom_range(0, 2));
      end
      ready_mode = 0;
      drain();

      // Reset in the middle of a group (phase P2), then a clean group
      send_auto(32'h0302_0100);
      send_auto(32'h0706_0504);
      idle(1);
      check("pre_reset_consumed", exp_q.size(), 0);
      reset_dut();
      send_auto(32'h4433_2211);
      send_auto(32'h8877_6655);
      send_auto(32'hCCBB_AA99);
      drain();

`ifdef UNPACKER_CHECK_EN
      // Framing errors: tlast on word 3, tuser on word 4 with resync
      reset_dut();
      send_auto($urandom());
      send_auto($urandom());
      send_auto($urandom());
      send_word($urandom(), 1'b0, 1'b1);
      check("err_eol_set", {63'h0, err_eol}, 64'h1);
      check("err_sof_quiet", {63'h0, err_sof}, 64'h0);
      send_word(32'h00C0_B0A0, 1'b1, 1'b0);
      check("err_sof_set", {63'h0, err_sof}, 64'h1);
      send_word($urandom(), 1'b0, 1'b0);
      send_word($urandom(), 1'b0, 1'b0);
      drain();
      reset_dut();
      check("err_clear", {err_sof, err_eol}, 64'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
